// File: rtl/mole_pkg.sv
// Shared types and helpers for the multi-channel mole dwell timer.
// The adaptive difficulty level is enabled by defining MOLE_DWELL_ADAPT_EN.
package mole_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } chan_state_t;

    localparam int unsigned MOLE_DWELL_MIN = 1;

    // max(x - y, 1) without underflow
    function automatic logic [31:0] dwell_floor(
        input logic [31:0] x,
        input logic [31:0] y
    );
        return (x > y) ? (x - y) : 32'(MOLE_DWELL_MIN);
    endfunction

endpackage

// File: rtl/mole_dwell_chan.sv
// One dwell-timer channel: IDLE/ACTIVE FSM, counter, latched threshold,
// registered one-tick expired/hit_ok pulses.
module mole_dwell_chan
    import mole_pkg::*;
#(
    parameter int WAIT_W = 3
) (
    input  logic              CLOCK_WAIT,
    input  logic              Mreset_wait,
    input  logic              i_clr,
    input  logic              i_pause,
    input  logic [WAIT_W-1:0] i_dwell_lat,
    input  logic              i_start,
    input  logic              i_hit,
    output logic [WAIT_W-1:0] o_cnt,
    output logic              o_active,
    output logic              o_expired,
    output logic              o_hit_ok,
    output logic              o_hit_ev,
    output logic              o_exp_ev
);

    chan_state_t       r_state;
    chan_state_t       w_state_n;
    logic [WAIT_W-1:0] r_cnt;
    logic [WAIT_W-1:0] w_cnt_n;
    logic [WAIT_W-1:0] r_dwell;
    logic [WAIT_W-1:0] w_dwell_n;
    logic              r_expired;
    logic              r_hit_ok;
    logic              w_hit_ev;
    logic              w_exp_ev;
    logic [WAIT_W:0]   w_cnt_inc;

    assign w_cnt_inc = {1'b0, r_cnt} + (WAIT_W+1)'(1);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_dwell_n = r_dwell;
        w_hit_ev  = 1'b0;
        w_exp_ev  = 1'b0;
        if (i_clr) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
            w_dwell_n = WAIT_W'(MOLE_DWELL_MIN);
        end else if (!i_pause) begin
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        w_state_n = ACTIVE;
                        w_cnt_n   = '0;
                        w_dwell_n = i_dwell_lat;
                    end
                end
                ACTIVE: begin
                    // a hit on the expiry edge wins over the timeout
                    if (i_hit) begin
                        w_state_n = IDLE;
                        w_hit_ev  = 1'b1;
                    end else if (w_cnt_inc == {1'b0, r_dwell}) begin
                        w_state_n = IDLE;
                        w_exp_ev  = 1'b1;
                        w_cnt_n   = r_dwell;
                    end else begin
                        w_cnt_n = w_cnt_inc[WAIT_W-1:0];
                    end
                end
                default: begin
                    w_state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_WAIT or posedge Mreset_wait) begin
        if (Mreset_wait) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_dwell   <= WAIT_W'(MOLE_DWELL_MIN);
            r_expired <= 1'b0;
            r_hit_ok  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_dwell   <= w_dwell_n;
            r_expired <= w_exp_ev;
            r_hit_ok  <= w_hit_ev;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_active  = (r_state == ACTIVE);
    assign o_expired = r_expired;
    assign o_hit_ok  = r_hit_ok;
    assign o_hit_ev  = w_hit_ev;
    assign o_exp_ev  = w_exp_ev;

endmodule

// File: rtl/mole_dwell_timer.sv
// NUM_MOLES independent dwell timers; optional shared difficulty level
// register and level port when MOLE_DWELL_ADAPT_EN is defined.
module mole_dwell_timer
    import mole_pkg::*;
#(
    parameter int NUM_MOLES = 4,
    parameter int WAIT_W    = 3
) (
    input  logic                        CLOCK_WAIT,
    input  logic                        Mreset_wait,
    input  logic                        clr,
    input  logic                        pause,
    input  logic [WAIT_W-1:0]           dwell,
    input  logic [NUM_MOLES-1:0]        start,
    input  logic [NUM_MOLES-1:0]        hit,
    output logic [NUM_MOLES*WAIT_W-1:0] wait_cnt,
    output logic [NUM_MOLES-1:0]        active,
    output logic [NUM_MOLES-1:0]        expired,
    output logic [NUM_MOLES-1:0]        hit_ok
`ifdef MOLE_DWELL_ADAPT_EN
    ,
    output logic [WAIT_W-1:0]           level
`endif
);

    logic [NUM_MOLES-1:0] w_hit_ev;
    logic [NUM_MOLES-1:0] w_exp_ev;
    logic [WAIT_W-1:0]    w_dwell_lat;

`ifdef MOLE_DWELL_ADAPT_EN
    logic [WAIT_W-1:0] r_level;

    // any expiry resets difficulty, even alongside a hit elsewhere
    always_ff @(posedge CLOCK_WAIT or posedge Mreset_wait) begin
        if (Mreset_wait) begin
            r_level <= '0;
        end else if (clr) begin
            r_level <= '0;
        end else if (|w_exp_ev) begin
            r_level <= '0;
        end else if ((|w_hit_ev) && (r_level != '1)) begin
            r_level <= r_level + WAIT_W'(1);
        end
    end

    assign level       = r_level;
    assign w_dwell_lat = WAIT_W'(dwell_floor(32'(dwell), 32'(r_level)));
`else
    logic w_unused_ev;

    assign w_unused_ev = ^{w_hit_ev, w_exp_ev};
    assign w_dwell_lat = WAIT_W'(dwell_floor(32'(dwell), 32'd0));
`endif

    for (genvar g = 0; g < NUM_MOLES; g++) begin : g_chan
        mole_dwell_chan #(
            .WAIT_W(WAIT_W)
        ) u_chan (
            .CLOCK_WAIT (CLOCK_WAIT),
            .Mreset_wait(Mreset_wait),
            .i_clr      (clr),
            .i_pause    (pause),
            .i_dwell_lat(w_dwell_lat),
            .i_start    (start[g]),
            .i_hit      (hit[g]),
            .o_cnt      (wait_cnt[g*WAIT_W +: WAIT_W]),
            .o_active   (active[g]),
            .o_expired  (expired[g]),
            .o_hit_ok   (hit_ok[g]),
            .o_hit_ev   (w_hit_ev[g]),
            .o_exp_ev   (w_exp_ev[g])
        );
    end

endmodule

// File: tb/tb_mole_dwell_timer.sv
// Directed plus random stimulus for mole_dwell_timer, checked against a
// per-channel behavioural model of elapsed ticks and thresholds.
module tb_mole_dwell_timer;

    localparam int N = 4;
    localparam int W = 3;
    localparam int CMAX = (1 << W) - 1;

    logic             CLOCK_WAIT = 1'b0;
    logic             Mreset_wait;
    logic             clr;
    logic             pause;
    logic [W-1:0]     dwell;
    logic [N-1:0]     start;
    logic [N-1:0]     hit;
    logic [N*W-1:0]   wait_cnt;
    logic [N-1:0]     active;
    logic [N-1:0]     expired;
    logic [N-1:0]     hit_ok;
`ifdef MOLE_DWELL_ADAPT_EN
    logic [W-1:0]     level;
`endif

    int total = 0;
    int bad = 0;

    int m_cnt [N];
    int m_lat [N];
    bit m_act [N];
    bit m_exp [N];
    bit m_hok [N];
    int m_lvl;

    always #5 CLOCK_WAIT = ~CLOCK_WAIT;

    mole_dwell_timer #(.NUM_MOLES(N), .WAIT_W(W)) dut (
        .CLOCK_WAIT (CLOCK_WAIT),
        .Mreset_wait(Mreset_wait),
        .clr        (clr),
        .pause      (pause),
        .dwell      (dwell),
        .start      (start),
        .hit        (hit),
        .wait_cnt   (wait_cnt),
        .active     (active),
        .expired    (expired),
        .hit_ok     (hit_ok)
`ifdef MOLE_DWELL_ADAPT_EN
        ,
        .level      (level)
`endif
    );

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_lat[i] = 1;
            m_act[i] = 0;
            m_exp[i] = 0;
            m_hok[i] = 0;
        end
        m_lvl = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] st, input logic [N-1:0] ht,
                              input logic pz, input logic cl, input int dw);
        int base;
        int lat_new;
        bit anyh;
        bit anye;
        anyh = 0;
        anye = 0;
        base = 0;
`ifdef MOLE_DWELL_ADAPT_EN
        base = m_lvl;
`endif
        lat_new = (dw - base < 1) ? 1 : dw - base;
        for (int i = 0; i < N; i++) begin
            m_exp[i] = 0;
            m_hok[i] = 0;
        end
        if (cl) begin
            model_reset();
        end else if (!pz) begin
            for (int i = 0; i < N; i++) begin
                if (!m_act[i]) begin
                    if (st[i]) begin
                        m_act[i] = 1;
                        m_cnt[i] = 0;
                        m_lat[i] = lat_new;
                    end
                end else if (ht[i]) begin
                    m_act[i] = 0;
                    m_hok[i] = 1;
                    anyh = 1;
                end else if (m_cnt[i] + 1 == m_lat[i]) begin
                    m_act[i] = 0;
                    m_exp[i] = 1;
                    m_cnt[i] = m_lat[i];
                    anye = 1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            if (anye) m_lvl = 0;
            else if (anyh && m_lvl < CMAX) m_lvl = m_lvl + 1;
        end
    endtask

    task automatic check(input string tag);
        logic [N*W-1:0] e_cnt;
        logic [N-1:0]   e_act;
        logic [N-1:0]   e_exp;
        logic [N-1:0]   e_hok;
        for (int i = 0; i < N; i++) begin
            e_cnt[i*W +: W] = W'(m_cnt[i]);
            e_act[i] = m_act[i];
            e_exp[i] = m_exp[i];
            e_hok[i] = m_hok[i];
        end
        total++;
        assert (wait_cnt === e_cnt) else begin
            bad++;
            $error("FAIL %s wait_cnt got=%h exp=%h", tag, wait_cnt, e_cnt);
        end
        total++;
        assert (active === e_act) else begin
            bad++;
            $error("FAIL %s active got=%b exp=%b", tag, active, e_act);
        end
        total++;
        assert (expired === e_exp) else begin
            bad++;
            $error("FAIL %s expired got=%b exp=%b", tag, expired, e_exp);
        end
        total++;
        assert (hit_ok === e_hok) else begin
            bad++;
            $error("FAIL %s hit_ok got=%b exp=%b", tag, hit_ok, e_hok);
        end
`ifdef MOLE_DWELL_ADAPT_EN
        total++;
        assert (level === W'(m_lvl)) else begin
            bad++;
            $error("FAIL %s level got=%0d exp=%0d", tag, level, m_lvl);
        end
`endif
    endtask

    task automatic step(input string tag, input logic [N-1:0] st,
                        input logic [N-1:0] ht, input logic pz,
                        input logic cl, input int dw);
        start = st;
        hit   = ht;
        pause = pz;
        clr   = cl;
        dwell = W'(dw);
        @(posedge CLOCK_WAIT);
        model_edge(st, ht, pz, cl, dw);
        #1 check(tag);
    endtask

    task automatic idle(input string tag, input int n, input int dw);
        for (int k = 0; k < n; k++) step(tag, '0, '0, 1'b0, 1'b0, dw);
    endtask

    initial begin
        Mreset_wait = 1'b1;
        clr   = 1'b0;
        pause = 1'b0;
        dwell = '0;
        start = '0;
        hit   = '0;
        model_reset();
        repeat (2) @(posedge CLOCK_WAIT);
        #1 check("reset");
        Mreset_wait = 1'b0;

        // asynchronous reset while ch0 is mid-count
        step("r_start", 4'b0001, '0, 0, 0, 5);
        idle("r_run", 2, 5);
        #2 Mreset_wait = 1'b1;
        model_reset();
        #1 check("async_rst");
        #1 Mreset_wait = 1'b0;

        // timeout with dwell=4
        step("to_start", 4'b0001, '0, 0, 0, 4);
        idle("to_run", 5, 4);

        // hit on the would-be expiry edge
        step("col_start", 4'b0010, '0, 0, 0, 3);
        idle("col_run", 2, 3);
        step("col_hit", '0, 4'b0010, 0, 0, 3);
        step("hit_idle", '0, 4'b0010, 0, 0, 3);

        // pause with ignored requests, dwell changed mid-run
        step("pz_start", 4'b0100, '0, 0, 0, 4);
        idle("pz_pre", 1, 4);
        for (int k = 0; k < 5; k++) step("pz_hold", 4'b1111, 4'b0100, 1, 0, 4);
        idle("pz_post", 4, 7);
        step("restart_ign", 4'b0100, '0, 0, 0, 7);
        idle("pz_tail", 2, 7);

        // dwell=0 and dwell=max
        step("d0_start", 4'b1000, '0, 0, 0, 0);
        idle("d0_run", 2, 0);
        step("d7_start", 4'b0001, '0, 0, 0, 7);
        idle("d7_run", 8, 7);

        // all channels together
        step("all_start", 4'b1111, '0, 0, 0, 2);
        idle("all_run", 3, 2);

        // soft clear mid-run
        step("clr_start", 4'b0011, '0, 0, 0, 6);
        idle("clr_pre", 2, 6);
        step("clr", 4'b1111, '0, 0, 1, 6);
        idle("clr_post", 1, 6);

`ifdef MOLE_DWELL_ADAPT_EN
        for (int k = 0; k < 7; k++) begin
            step("lv_start", 4'b0001, '0, 0, 0, 6);
            step("lv_hit", '0, 4'b0001, 0, 0, 6);
        end
        step("lv_latch1", 4'b0010, '0, 0, 0, 6);
        idle("lv_exp", 2, 6);
        step("lv_both", 4'b0011, '0, 0, 0, 2);
        step("lv_cnt", '0, '0, 0, 0, 2);
        step("lv_hit", 4'b0001, 4'b0001, 0, 0, 2);
        step("lv_hit_x", '0, '0, 0, 0, 2);
`endif

        // random phase
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] st;
            logic [N-1:0] ht;
            st = N'($urandom) & N'($urandom);
            ht = N'($urandom) & N'($urandom) & N'($urandom);
            step("rand", st, ht, ($urandom_range(7) == 0),
                 ($urandom_range(49) == 0), int'($urandom_range(CMAX)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
